muldiv_seq: RTL and testbench
=============================

Name: muldiv_seq

Overview:
- Multi-cycle iterative multiply/divide sequencer for MIOP_MUL/MIOP_DIV (and the MULI/DIVI forms, which the decoder folds to MUL/DIV). The single-cycle ALU returns d=0 for these ops.
- Sits beside the ALU in the execute stage.
- Accepts one operation through a valid/ready request handshake, runs a radix-2 shift-add or shift-subtract loop over the selected operand width, and returns the result through a valid/ready response handshake.
- Execute stalls on req_ready/resp_valid.

Parameters:
- REG_W, 64, datapath width; must equal `REG_W of reg_t.
- CNT_W, 7, iteration counter width; must satisfy 2^CNT_W > REG_W.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  pipeline kill; aborts any in-flight operation.
- req_valid  input  1  request present.
- req_ready  output  1  sequencer can accept a request.
- req_div  input  1  0=multiply, 1=divide.
- req_signed  input  1  1=two's-complement operands, 0=unsigned.
- req_bmd  input  bmd_t  operand width: BMD_08/16/32, otherwise 64.
- req_s  input  REG_W  multiplicand / dividend.
- req_t  input  REG_W  multiplier / divisor.
- resp_valid  output  1  result present.
- resp_ready  input  1  consumer takes the result.
- resp_lo  output  REG_W  low product half / quotient.
- resp_hi  output  REG_W  high product half / remainder.
- resp_dz  output  1  divide by zero.
- resp_of  output  1  multiply: high half non-zero (unsigned) or not the sign-extension of lo (signed); divide: signed MIN/-1.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; req_ready=1; resp_valid=0; resp_lo=0; resp_hi=0; resp_dz=0; resp_of=0; counter=0. Reset overrides flush and any handshake in the same cycle.
- Operand width W: 8, 16, 32 or 64 from req_bmd. Operands are truncated to W bits. If req_signed=1 they are sign-interpreted at bit W-1; magnitudes are taken and the result signs are recorded at accept.
- States:
  - IDLE: req_ready=1. On req_valid&req_ready with flush=0, latch the operands, width and signs.
    - Divide with t[W-1:0]==0: go to DONE. Set resp_lo = W-bit all-ones zero-extended, resp_hi = s[W-1:0] zero-extended, dz=1, of=0.
    - Signed divide with s=MIN_W and t=-1: go to DONE. Set lo = MIN_W, hi = 0, of=1, dz=0.
    - Otherwise go to CALC with counter=W.
  - CALC: req_ready=0. One iteration per cycle.
    - Multiply: add the multiplicand to the 2W-bit accumulator if the multiplier LSB=1, then shift right.
    - Divide: restoring shift-subtract, MSB first.
    - Counter decrements each cycle. When counter reaches 1 this cycle, apply sign fixups and go to DONE:
      - multiply: negate the 2W product if the signs differ;
      - divide: quotient negated if the signs differ, remainder takes the dividend's sign.
  - DONE: resp_valid=1 and the outputs are held stable until resp_valid&resp_ready, then go to IDLE. req_ready=0 while in DONE; there is no back-to-back accept in the same cycle.
- Latency: accept at cycle 0; resp_valid at cycle W+1 (9, 17, 33 or 65). Divide-by-zero and MIN/-1 give resp_valid at cycle 1.
- Output formatting: resp_lo and resp_hi are the W-bit results zero-extended to REG_W, matching the ALU's logical results.
- flush: in any state, the next state is IDLE, resp_valid=0 and the operation is discarded. A req_valid in the same cycle as flush is not accepted. Output data registers may retain stale values; they are don't-care while resp_valid=0.
- resp_valid never drops without resp_ready or flush. resp_* are registered outputs; there is no combinational path from req_* to resp_*.
- Only one operation is in flight. No eflags update; eflags handling is the caller's responsibility.

Test Plan:
- Unsigned MUL, bmd=BMD_64, s=0xFFFF_FFFF_FFFF_FFFF, t=2 -> resp_valid at cycle 65; lo=0xFFFF_FFFF_FFFF_FFFE, hi=1, of=1, dz=0.
- Signed DIV, BMD_32, s=-7 (0xFFFF_FFF9), t=2 -> resp_valid at cycle 33; lo=0x0000_0000_FFFF_FFFD (-3), hi=0x0000_0000_FFFF_FFFF (-1), of=0.
- DIV, BMD_16, t=0, s=0x1234 -> resp_valid at cycle 1; lo=0xFFFF, hi=0x1234, dz=1.
- Signed DIV, BMD_08, s=0x80, t=0xFF -> resp_valid at cycle 1; lo=0x80, hi=0, of=1.
- Backpressure and reset:
  - MUL, BMD_08, 12*13 with resp_ready=0 for 5 cycles -> resp_valid held at lo=0x9C, hi=0, req_ready=0 throughout; IDLE the cycle after resp_ready=1.
  - Then rst=1 during CALC -> all outputs 0 and req_ready=1 on the next cycle.
- flush in CALC at cycle 4, with a new req_valid in the same cycle -> no resp_valid; the new request is not accepted; IDLE next cycle; a subsequent request completes normally.

Source files
------------

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative radix-2 multiply/divide sequencer for the execute stage.
// It accepts one operation through a valid/ready request handshake. It runs one
// shift-add (multiply) or restoring shift-subtract (divide) step per cycle over
// the selected width W. It returns a registered result through a valid/ready
// response handshake.
//
// Ports:
//   clk_i, rst_i    clock, synchronous active-high reset
//   flush_i         pipeline kill; aborts any in-flight operation
//   req_valid_i     request present
//   req_ready_o     sequencer can accept a request
//   req_div_i       0=multiply, 1=divide
//   req_signed_i    1=two's-complement operands
//   req_bmd_i       width: 0=8, 1=16, 2=32, 3=64 bits
//   req_s_i         multiplicand / dividend
//   req_t_i         multiplier / divisor
//   resp_valid_o    result present
//   resp_ready_i    consumer takes the result
//   resp_lo_o       low product half / quotient (W bits, zero-extended)
//   resp_hi_o       high product half / remainder (W bits, zero-extended)
//   resp_dz_o       divide by zero
//   resp_of_o       multiply high half significant, or signed MIN/-1 divide
module muldiv_seq #(
  parameter int unsigned REG_W = 64,
  parameter int unsigned CNT_W = 7
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_div_i,
  input  logic             req_signed_i,
  input  logic [1:0]       req_bmd_i,
  input  logic [REG_W-1:0] req_s_i,
  input  logic [REG_W-1:0] req_t_i,
  output logic             resp_valid_o,
  input  logic             resp_ready_i,
  output logic [REG_W-1:0] resp_lo_o,
  output logic [REG_W-1:0] resp_hi_o,
  output logic             resp_dz_o,
  output logic             resp_of_o
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

  state_e state_q, state_d;

  // Working registers: a_q = product high half / partial remainder,
  // b_q = multiplier / dividend-quotient, m_q = multiplicand / divisor.
  logic [REG_W-1:0] a_q, b_q, m_q;
  logic [REG_W-1:0] mask_q, msb_q;
  logic [CNT_W-1:0] cnt_q;
  logic             div_q, sgn_q, neg_q, sneg_q;
  logic [REG_W-1:0] res_lo_q, res_hi_q;
  logic             dz_q, of_q;

  function automatic logic [REG_W-1:0] neg_w(input logic [REG_W-1:0] x,
                                             input logic [REG_W-1:0] m);
    return (~x + REG_W'(1)) & m;
  endfunction

  // ---------------- request decode ----------------
  logic [REG_W-1:0] req_mask, req_msb, s_w, t_w, s_mag, t_mag;
  logic [CNT_W-1:0] req_w;
  logic             s_neg, t_neg, dz_case, ovf_case, accept;

  always_comb begin
    case (req_bmd_i)
      2'b00:   begin req_mask = REG_W'(8'hFF);         req_w = CNT_W'(8);  end
      2'b01:   begin req_mask = REG_W'(16'hFFFF);      req_w = CNT_W'(16); end
      2'b10:   begin req_mask = REG_W'(32'hFFFF_FFFF); req_w = CNT_W'(32); end
      default: begin req_mask = '1;                    req_w = CNT_W'(REG_W); end
    endcase
    req_msb  = req_mask ^ (req_mask >> 1);
    s_w      = req_s_i & req_mask;
    t_w      = req_t_i & req_mask;
    s_neg    = req_signed_i && ((s_w & req_msb) != '0);
    t_neg    = req_signed_i && ((t_w & req_msb) != '0);
    s_mag    = s_neg ? neg_w(s_w, req_mask) : s_w;
    t_mag    = t_neg ? neg_w(t_w, req_mask) : t_w;
    dz_case  = req_div_i && (t_w == '0);
    ovf_case = req_div_i && req_signed_i && (s_w == req_msb) && (t_w == req_mask);
    accept   = (state_q == S_IDLE) && req_valid_i && !flush_i;
  end

  // ---------------- one iteration + final sign fixups ----------------
  logic [REG_W:0]   sum, shifted;
  logic             ge;
  logic [REG_W-1:0] step_lo, step_hi, fin_lo, fin_hi;
  logic             fin_of;

  always_comb begin
    // Multiply: the carry out of the W-bit add lands in bit W-1 of hi after
    // the right shift; the bit shifted out of hi enters lo at bit W-1.
    sum     = {1'b0, a_q} + (b_q[0] ? {1'b0, m_q} : '0);
    // Divide: bring down the next dividend bit (MSB of the W-bit field).
    shifted = {a_q, (b_q & msb_q) != '0};
    ge      = shifted >= {1'b0, m_q};
    step_hi = '0;
    step_lo = '0;
    fin_hi  = '0;
    fin_lo  = '0;
    fin_of  = 1'b0;
    if (div_q) begin
      // When ge holds the difference is below m_q, so REG_W bits suffice.
      step_hi = ge ? (shifted[REG_W-1:0] - m_q) : shifted[REG_W-1:0];
      step_lo = ((b_q << 1) | REG_W'(ge)) & mask_q;
      fin_lo  = neg_q  ? neg_w(step_lo, mask_q) : step_lo;
      fin_hi  = sneg_q ? neg_w(step_hi, mask_q) : step_hi;
    end else begin
      step_hi = sum[REG_W:1];
      step_lo = (b_q >> 1) | (sum[0] ? msb_q : '0);
      if (neg_q) begin
        // 2W-bit negate: the +1 carries into hi only when lo is zero.
        fin_lo = neg_w(step_lo, mask_q);
        fin_hi = (~step_hi + REG_W'(step_lo == '0)) & mask_q;
      end else begin
        fin_lo = step_lo;
        fin_hi = step_hi;
      end
      if (sgn_q) fin_of = fin_hi != (((fin_lo & msb_q) != '0) ? mask_q : '0);
      else       fin_of = fin_hi != '0;
    end
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = (dz_case || ovf_case) ? S_DONE : S_CALC;
      S_CALC: if (cnt_q == CNT_W'(1)) state_d = S_DONE;
      S_DONE: if (resp_ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush_i) state_d = S_IDLE;
  end

  always_comb begin
    req_ready_o  = (state_q == S_IDLE);
    resp_valid_o = (state_q == S_DONE);
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_q      <= '0;
      b_q      <= '0;
      m_q      <= '0;
      mask_q   <= '0;
      msb_q    <= '0;
      cnt_q    <= '0;
      div_q    <= 1'b0;
      sgn_q    <= 1'b0;
      neg_q    <= 1'b0;
      sneg_q   <= 1'b0;
      res_lo_q <= '0;
      res_hi_q <= '0;
      dz_q     <= 1'b0;
      of_q     <= 1'b0;
    end else if (accept) begin
      a_q    <= '0;
      b_q    <= req_div_i ? s_mag : t_mag;
      m_q    <= req_div_i ? t_mag : s_mag;
      mask_q <= req_mask;
      msb_q  <= req_msb;
      cnt_q  <= req_w;
      div_q  <= req_div_i;
      sgn_q  <= req_signed_i;
      neg_q  <= s_neg ^ t_neg;
      sneg_q <= s_neg;
      if (dz_case) begin
        res_lo_q <= req_mask;
        res_hi_q <= s_w;
        dz_q     <= 1'b1;
        of_q     <= 1'b0;
      end else if (ovf_case) begin
        res_lo_q <= req_msb;
        res_hi_q <= '0;
        dz_q     <= 1'b0;
        of_q     <= 1'b1;
      end
    end else if (state_q == S_CALC && !flush_i) begin
      a_q   <= step_hi;
      b_q   <= step_lo;
      cnt_q <= cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        res_lo_q <= fin_lo;
        res_hi_q <= fin_hi;
        dz_q     <= 1'b0;
        of_q     <= fin_of;
      end
    end
  end

  assign resp_lo_o = res_lo_q;
  assign resp_hi_o = res_hi_q;
  assign resp_dz_o = dz_q;
  assign resp_of_o = of_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: the driver pushes hand-computed expected
// responses; an independent monitor compares them whenever resp_valid is high.
module tb_muldiv_seq;

  localparam logic [1:0] BMD_08 = 2'd0;
  localparam logic [1:0] BMD_16 = 2'd1;
  localparam logic [1:0] BMD_32 = 2'd2;
  localparam logic [1:0] BMD_64 = 2'd3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_div = 1'b0;
  logic        req_signed = 1'b0;
  logic [1:0]  req_bmd = BMD_64;
  logic [63:0] req_s = '0;
  logic [63:0] req_t = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [63:0] resp_lo, resp_hi;
  logic        resp_dz, resp_of;

  muldiv_seq #(.REG_W(64), .CNT_W(7)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_div_i(req_div), .req_signed_i(req_signed), .req_bmd_i(req_bmd),
    .req_s_i(req_s), .req_t_i(req_t),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
    .resp_lo_o(resp_lo), .resp_hi_o(resp_hi),
    .resp_dz_o(resp_dz), .resp_of_o(resp_of)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  typedef struct {
    logic [63:0] lo;
    logic [63:0] hi;
    logic        dz;
    logic        of;
    int          lat;
    int          t0;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: latency on the first valid cycle, data and req_ready on every
  // valid cycle, pop on handshake.
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    if (resp_valid === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: resp_valid=1 with lo=0x%0h, expected no response", resp_lo);
      end else begin
        if (!prev_valid) chk("latency", 64'(cyc - q[0].t0), 64'(q[0].lat));
        chk("resp_lo", resp_lo, q[0].lo);
        chk("resp_hi", resp_hi, q[0].hi);
        chk("resp_dz", 64'(resp_dz), 64'(q[0].dz));
        chk("resp_of", 64'(resp_of), 64'(q[0].of));
        chk("req_ready_in_done", 64'(req_ready), 64'(0));
        if (resp_ready) void'(q.pop_front());
      end
    end
    prev_valid = resp_valid;
  end

  // Called at posedge+1; presents one request for exactly one edge.
  task automatic drive(input logic div, input logic sgn, input logic [1:0] bmd,
                       input logic [63:0] s, input logic [63:0] t, output int t0);
    int k = 0;
    while (!req_ready && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    if (!req_ready) chk("req_ready_timeout", 64'(req_ready), 64'(1));
    req_div = div; req_signed = sgn; req_bmd = bmd; req_s = s; req_t = t;
    req_valid = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while (q.size() != 0 && k < 300) begin
      @(posedge clk); #1;
      k++;
    end
    if (q.size() != 0) begin
      chk("resp_timeout", 64'(q.size()), 64'(0));
      q.delete();
    end
  endtask

  task automatic run(input logic div, input logic sgn, input logic [1:0] bmd,
                     input logic [63:0] s, input logic [63:0] t,
                     input logic [63:0] elo, input logic [63:0] ehi,
                     input logic edz, input logic eof, input int elat);
    int t0;
    exp_t e;
    drive(div, sgn, bmd, s, t, t0);
    e.lo = elo; e.hi = ehi; e.dz = edz; e.of = eof; e.lat = elat; e.t0 = t0;
    q.push_back(e);
    drain();
  endtask

  initial begin
    int t0;
    int k;
    exp_t e;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'(1));
    chk("rst_resp_valid", 64'(resp_valid), 64'(0));
    chk("rst_lo", resp_lo, 64'h0);
    chk("rst_hi", resp_hi, 64'h0);
    chk("rst_dz", 64'(resp_dz), 64'(0));
    chk("rst_of", 64'(resp_of), 64'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    //  div  sgn  bmd     s                      t                      lo                     hi                     dz  of  lat
    run(1'b0, 1'b0, BMD_64, 64'hFFFF_FFFF_FFFF_FFFF, 64'h2, 64'hFFFF_FFFF_FFFF_FFFE, 64'h1, 1'b0, 1'b1, 65);
    run(1'b1, 1'b1, BMD_32, 64'hFFFF_FFF9, 64'h2, 64'hFFFF_FFFD, 64'hFFFF_FFFF, 1'b0, 1'b0, 33);
    run(1'b1, 1'b0, BMD_16, 64'h1234, 64'h0, 64'hFFFF, 64'h1234, 1'b1, 1'b0, 1);
    run(1'b1, 1'b1, BMD_08, 64'h80, 64'hFF, 64'h80, 64'h0, 1'b0, 1'b1, 1);
    run(1'b0, 1'b1, BMD_08, 64'hFD, 64'h05, 64'hF1, 64'hFF, 1'b0, 1'b0, 9);
    run(1'b0, 1'b0, BMD_16, 64'h1234, 64'h10, 64'h2340, 64'h1, 1'b0, 1'b1, 17);
    run(1'b1, 1'b0, BMD_64, 64'd100, 64'd7, 64'd14, 64'd2, 1'b0, 1'b0, 65);
    run(1'b1, 1'b0, BMD_08, 64'hABCD_00C8, 64'h103, 64'h42, 64'h2, 1'b0, 1'b0, 9);
    run(1'b0, 1'b1, BMD_32, 64'h8000_0000, 64'h8000_0000, 64'h0, 64'h4000_0000, 1'b0, 1'b1, 33);
    run(1'b1, 1'b1, BMD_16, 64'h7, 64'hFFFE, 64'hFFFD, 64'h1, 1'b0, 1'b0, 17);
    run(1'b1, 1'b1, BMD_08, 64'h80, 64'h01, 64'h80, 64'h0, 1'b0, 1'b0, 9);

    // Backpressure: 12*13 held for 5 cycles, then released.
    resp_ready = 1'b0;
    drive(1'b0, 1'b0, BMD_08, 64'd12, 64'd13, t0);
    e.lo = 64'h9C; e.hi = 64'h0; e.dz = 1'b0; e.of = 1'b0; e.lat = 9; e.t0 = t0;
    q.push_back(e);
    k = 0;
    while (!resp_valid && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    chk("bp_valid_seen", 64'(resp_valid), 64'(1));
    repeat (5) begin
      @(posedge clk); #1;
    end
    chk("bp_valid_held", 64'(resp_valid), 64'(1));
    resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_idle_valid", 64'(resp_valid), 64'(0));
    chk("bp_idle_ready", 64'(req_ready), 64'(1));
    chk("bp_popped", 64'(q.size()), 64'(0));
    q.delete();

    // Reset during CALC clears everything, including the held 0x9C result.
    drive(1'b0, 1'b0, BMD_64, 64'h1234_5678, 64'h9ABC, t0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("calc_busy", 64'(req_ready), 64'(0));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_calc_ready", 64'(req_ready), 64'(1));
    chk("rst_calc_valid", 64'(resp_valid), 64'(0));
    chk("rst_calc_lo", resp_lo, 64'h0);
    chk("rst_calc_hi", resp_hi, 64'h0);
    chk("rst_calc_dz", 64'(resp_dz), 64'(0));
    chk("rst_calc_of", 64'(resp_of), 64'(0));

    // Flush in CALC with a simultaneous new request: neither completes.
    drive(1'b0, 1'b0, BMD_64, 64'hFFFF, 64'hFFFF, t0);
    repeat (2) begin
      @(posedge clk); #1;
    end
    flush = 1'b1;
    req_valid = 1'b1; req_div = 1'b1; req_signed = 1'b0; req_bmd = BMD_08;
    req_s = 64'd9; req_t = 64'd0;
    @(posedge clk); #1;
    flush = 1'b0;
    req_valid = 1'b0;
    chk("flush_idle_ready", 64'(req_ready), 64'(1));
    chk("flush_idle_valid", 64'(resp_valid), 64'(0));
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("flush_not_accepted", 64'(req_ready), 64'(1));
    chk("flush_no_resp", 64'(resp_valid), 64'(0));

    run(1'b0, 1'b0, BMD_32, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'h1, 64'hFFFF_FFFE, 1'b0, 1'b1, 33);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

endmodule
